// File: rtl/window_gen.sv
// Streaming 6x6 sliding-window generator with five line buffers for the Harris pipeline.
// Optional: define WINGEN_WIN_COUNT_EN to add a saturating win_count output.
module window_gen #(
   parameter int IMG_W = 640,
   parameter int IMG_H = 480
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  pix_in,
   input  logic        pix_valid,
   input  logic        pix_sof,
   output logic [7:0]  window [0:5][0:5],
   output logic        win_valid,
   output logic        frame_done
`ifdef WINGEN_WIN_COUNT_EN
   ,
   output logic [31:0] win_count
`endif
);

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);

   logic [CW-1:0] col_q, col_d, cur_col;
   logic [RW-1:0] row_q, row_d, cur_row;
   logic          accept;
   logic          win_valid_d, frame_done_d;
   logic          win_valid_q, frame_done_q;
   logic [7:0]    window_q [0:5][0:5];
   logic [7:0]    new_col  [0:5];
   logic [7:0]    lb_q     [0:4][0:IMG_W-1];

   assign accept = pix_valid & ~reset;

   // An accepted sof pixel is (0,0) no matter where the counters stand.
   always_comb begin
      cur_col = pix_sof ? '0 : col_q;
      cur_row = pix_sof ? '0 : row_q;
      col_d   = cur_col + 1'b1;
      row_d   = cur_row;
      if (cur_col == CW'(IMG_W - 1)) begin
         col_d = '0;
         row_d = (cur_row == RW'(IMG_H - 1)) ? '0 : cur_row + 1'b1;
      end
   end

   always_comb begin
      new_col[5] = pix_in;
      for (int k = 0; k < 5; k++) new_col[4-k] = lb_q[k][cur_col];
   end

   assign win_valid_d  = (cur_row >= RW'(5)) && (cur_col >= CW'(5));
   assign frame_done_d = (cur_row == RW'(IMG_H - 1)) && (cur_col == CW'(IMG_W - 1));

   // Line-buffer RAM carries no reset; stale contents never reach a valid window.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb_q[0][cur_col] <= pix_in;
         for (int k = 1; k < 5; k++) lb_q[k][cur_col] <= lb_q[k-1][cur_col];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         col_q        <= '0;
         row_q        <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         for (int i = 0; i < 6; i++)
            for (int j = 0; j < 6; j++) window_q[i][j] <= '0;
      end else begin
         win_valid_q  <= pix_valid & win_valid_d;
         frame_done_q <= pix_valid & frame_done_d;
         if (pix_valid) begin
            col_q <= col_d;
            row_q <= row_d;
            for (int i = 0; i < 6; i++) begin
               for (int j = 0; j < 5; j++) window_q[i][j] <= window_q[i][j+1];
               window_q[i][5] <= new_col[i];
            end
         end
      end
   end

   assign window     = window_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;

`ifdef WINGEN_WIN_COUNT_EN
   logic [31:0] win_count_q;

   // Increments on the same edge that raises win_valid, so both appear together.
   always_ff @(posedge clk) begin
      if (reset || (pix_valid && pix_sof))
         win_count_q <= '0;
      else if (pix_valid && win_valid_d && (win_count_q != 32'hFFFF_FFFF))
         win_count_q <= win_count_q + 32'd1;
   end

   assign win_count = win_count_q;
`endif

endmodule

// File: tb/tb_window_gen.sv
// Directed bench for window_gen on an 8x8 image with pix_in = row*16 + col.
module tb_window_gen;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  pix_in = '0;
   logic        pix_valid = 1'b0;
   logic        pix_sof = 1'b0;
   logic [7:0]  win [0:5][0:5];
   logic        win_valid;
   logic        frame_done;
`ifdef WINGEN_WIN_COUNT_EN
   logic [31:0] win_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   window_gen #(.IMG_W(8), .IMG_H(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .pix_in     (pix_in),
      .pix_valid  (pix_valid),
      .pix_sof    (pix_sof),
      .window     (win),
      .win_valid  (win_valid),
      .frame_done (frame_done)
`ifdef WINGEN_WIN_COUNT_EN
      ,
      .win_count  (win_count)
`endif
   );

   typedef struct {
      logic       v;
      logic       sof;
      logic [7:0] pix;
      logic       exp_v;
      logic       chk_w;
      logic [7:0] w00;
      logic [7:0] w50;
      logic [7:0] w55;
   } vec_t;

   task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [287:0] pack_dut();
      logic [287:0] p;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) p[(i*6+j)*8 +: 8] = win[i][j];
      return p;
   endfunction

   function automatic logic [287:0] exp_win(input int r, input int c);
      logic [287:0] p;
      for (int i = 0; i < 6; i++)
         for (int j = 0; j < 6; j++) p[(i*6+j)*8 +: 8] = 8'((r-5+i)*16 + (c-5+j));
      return p;
   endfunction

   task automatic step(input logic v, input logic s, input logic [7:0] p);
      @(negedge clk);
      pix_valid = v;
      pix_sof   = s;
      pix_in    = p;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic v);
      @(negedge clk);
      reset     = 1'b1;
      pix_valid = v;
      pix_sof   = 1'b0;
      pix_in    = 8'hAA;
      @(posedge clk);
      #1;
      check("reset_window", pack_dut(), '0);
      check("reset_win_valid", 288'(win_valid), 288'(0));
      check("reset_frame_done", 288'(frame_done), 288'(0));
`ifdef WINGEN_WIN_COUNT_EN
      check("reset_win_count", 288'(win_count), 288'(0));
`endif
      @(negedge clk);
      reset     = 1'b0;
      pix_valid = 1'b0;
   endtask

   task automatic run_frame(input bit toggle, input bit sof, input string tag);
      int pulses = 0;
      logic [287:0] held;
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 8; c++) begin
            step(1'b1, sof && r == 0 && c == 0, 8'(r*16 + c));
            check({tag, "_win_valid"}, 288'(win_valid), 288'(r >= 5 && c >= 5));
            check({tag, "_frame_done"}, 288'(frame_done), 288'(r == 7 && c == 7));
            if (win_valid) pulses++;
            if (r >= 5 && c >= 5) check({tag, "_window"}, pack_dut(), exp_win(r, c));
            if (toggle) begin
               held = pack_dut();
               step(1'b0, 1'b0, 8'hFF);
               check({tag, "_gap_win_valid"}, 288'(win_valid), 288'(0));
               check({tag, "_gap_frame_done"}, 288'(frame_done), 288'(0));
               check({tag, "_gap_window_hold"}, pack_dut(), held);
            end
         end
      end
      check({tag, "_pulse_count"}, 288'(pulses), 288'(9));
   endtask

   vec_t tbl [9];

   initial begin
      tbl[0] = '{1'b1, 1'b0, 8'h60, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[1] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[2] = '{1'b1, 1'b0, 8'h61, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[3] = '{1'b1, 1'b0, 8'h62, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[4] = '{1'b1, 1'b0, 8'h63, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[5] = '{1'b1, 1'b0, 8'h64, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      tbl[6] = '{1'b1, 1'b0, 8'h65, 1'b1, 1'b1, 8'h10, 8'h60, 8'h65};
      tbl[7] = '{1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, 8'h10, 8'h60, 8'h65};
      tbl[8] = '{1'b1, 1'b0, 8'h66, 1'b1, 1'b1, 8'h11, 8'h61, 8'h66};

      do_reset(1'b0);

      // Continuous frame, then final-window contents and single frame_done.
      run_frame(1'b0, 1'b1, "cont");
      check("last_w00", 288'(win[0][0]), 288'(8'h22));
      check("last_w55", 288'(win[5][5]), 288'(8'h77));
      step(1'b0, 1'b0, 8'h00);
      check("fd_once", 288'(frame_done), 288'(0));
      check("idle_win_valid", 288'(win_valid), 288'(0));

      // Gapped frame without sof relies on the counters wrapping.
      run_frame(1'b1, 1'b0, "gap");

      // Partial frame, reset coinciding with a valid pixel, then a full frame.
      for (int i = 0; i < 30; i++) begin
         step(1'b1, i == 0, 8'(8'hC0 + i));
         check("partial_win_valid", 288'(win_valid), 288'(0));
      end
      do_reset(1'b1);
      run_frame(1'b0, 1'b0, "postrst");

      // Frame aborted by sof on its 20th pixel.
      for (int i = 0; i < 19; i++) begin
         step(1'b1, i == 0, 8'(8'hE0 + i));
         check("abort_win_valid", 288'(win_valid), 288'(0));
      end
      run_frame(1'b0, 1'b1, "sof");
`ifdef WINGEN_WIN_COUNT_EN
      check("win_count_end", 288'(win_count), 288'(9));
`endif

      // Row 6 table: no window before column 5, idle cycles hold.
      do_reset(1'b0);
      for (int r = 0; r < 6; r++)
         for (int c = 0; c < 8; c++) step(1'b1, r == 0 && c == 0, 8'(r*16 + c));
      for (int k = 0; k < 9; k++) begin
         step(tbl[k].v, tbl[k].sof, tbl[k].pix);
         check($sformatf("tbl%0d_win_valid", k), 288'(win_valid), 288'(tbl[k].exp_v));
         if (tbl[k].chk_w) begin
            check($sformatf("tbl%0d_w00", k), 288'(win[0][0]), 288'(tbl[k].w00));
            check($sformatf("tbl%0d_w50", k), 288'(win[5][0]), 288'(tbl[k].w50));
            check($sformatf("tbl%0d_w55", k), 288'(win[5][5]), 288'(tbl[k].w55));
         end
      end

      @(negedge clk);
      pix_valid = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
